spi_irq_ctrl: RTL
=================

SPI_IRQ_CTRL -- requirements
Module: spi_irq_ctrl

Interface
REQ-001 Parameter NSRC, default 4, number of interrupt sources (1..8).
REQ-002 Parameter TMO_W, default 16, width of the coalescing timeout counter.
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 avs_s0_write  in  1  Avalon-MM slave write strobe.
REQ-006 avs_s0_read  in  1  Avalon-MM slave read strobe.
REQ-007 avs_s0_address  in  16  register address; only values 0..5 decode, all others ignored (reads return 0).
REQ-008 avs_s0_writedata  in  32  write data.
REQ-009 avs_s0_readdata  out  32  read data, registered.
REQ-010 irq_src  in  NSRC  per-source interrupt requests, level-sampled every cycle.
REQ-011 avm_s0_irq  out  1  aggregated interrupt to the host, registered.

Function
REQ-012 Register map: 0 ACK (W1C on PENDING), 1 MASK (RW, NSRC bits), 2 PENDING (RO), 3 CAUSE (RO), 4 THRESH (RW, 8 bits), 5 TIMEOUT (RW, TMO_W bits).
REQ-013 PENDING[i] shall set on any cycle irq_src[i]=1 and clear on ACK write with writedata[i]=1; set wins over clear in the same cycle.
REQ-014 Sources with MASK[i]=0 still latch into PENDING but shall not contribute to ACTIVE = PENDING & MASK.
REQ-015 CAUSE = {valid bit 8, index bits 2:0}: lowest-index set bit of ACTIVE; valid=0 and index=0 when ACTIVE=0.
REQ-016 Reads shall return data one cycle after avs_s0_read is sampled; readdata holds its value otherwise; unused bits read 0.
REQ-017 FSM states IDLE, COAL, FIRE.
REQ-018 IDLE: avm_s0_irq=0; if ACTIVE!=0 -> FIRE when THRESH<=1, else -> COAL with event count=1 and timer=0.
REQ-019 COAL: count +1 per cycle in which a newly set ACTIVE bit appears (0->1 transition of any bit, counted once per cycle); timer +1 per cycle, saturating.
REQ-020 COAL -> FIRE when count>=THRESH or (TIMEOUT!=0 and timer>=TIMEOUT); COAL -> IDLE if ACTIVE becomes 0 (acked or masked before firing).
REQ-021 FIRE: avm_s0_irq=1; FIRE -> IDLE on the cycle after ACTIVE becomes 0.
REQ-022 avm_s0_irq shall be a registered decode of state (asserted exactly while state=FIRE).
REQ-023 Event counter is 8 bits and saturates at 255; it never wraps.
REQ-024 THRESH=0 shall behave as THRESH=1; TIMEOUT=0 disables the timeout.
REQ-025 Writes to MASK/THRESH/TIMEOUT during COAL shall take effect on the next comparison cycle without restarting count or timer.

Reset
REQ-026 rst shall clear PENDING, count, timer, readdata, avm_s0_irq to 0, set MASK to all ones, THRESH to 1, TIMEOUT to 0, state to IDLE.
REQ-027 rst asserted mid-COAL or mid-FIRE shall drop avm_s0_irq the following cycle; irq_src sampled during rst is discarded.

Structure
REQ-028 Register addresses, FSM state encoding and reset values shall reside in shared package spi_irq_pkg.
REQ-029 The lowest-index priority encoder shall be sub-module spi_irq_prio_enc (NSRC in, index + valid out, combinational).

Verification
REQ-030 Reset defaults: after rst, read addr 1 -> 0xF, addr 4 -> 1, addr 3 -> 0, avm_s0_irq=0.
REQ-031 Immediate fire: THRESH=1, pulse irq_src=4'b0100 one cycle -> avm_s0_irq=1 within 2 cycles, CAUSE=0x102; ACK write 0x4 -> irq=0 within 2 cycles.
REQ-032 Coalescing: THRESH=3, TIMEOUT=0, pulses on src0, src1, src3 spaced 5 cycles apart -> irq stays 0 until cycle after third pulse, then 1; CAUSE=0x100.
REQ-033 Timeout: THRESH=10, TIMEOUT=20, one pulse on src2 -> irq asserts 20-22 cycles after the pulse.
REQ-034 Set/clear collision: irq_src[1]=1 in the same cycle as ACK write 0x2 -> PENDING[1] remains 1, irq remains asserted.
REQ-035 Masking: MASK=0xE, pulse src0 -> PENDING=0x1, irq stays 0; write MASK=0xF -> irq asserts (THRESH=1).

Source files
------------

// File: rtl/spi_irq_pkg.sv
// Shared definitions for the SPI interrupt controller: register map,
// FSM encoding and reset values.
package spi_irq_pkg;

  localparam logic [15:0] ADDR_ACK     = 16'd0;
  localparam logic [15:0] ADDR_MASK    = 16'd1;
  localparam logic [15:0] ADDR_PENDING = 16'd2;
  localparam logic [15:0] ADDR_CAUSE   = 16'd3;
  localparam logic [15:0] ADDR_THRESH  = 16'd4;
  localparam logic [15:0] ADDR_TIMEOUT = 16'd5;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COAL = 2'd1,
    ST_FIRE = 2'd2
  } irq_state_e;

  localparam logic [7:0]       RST_MASK    = 8'hFF;
  localparam logic [CNT_W-1:0] RST_THRESH  = 8'd1;
  localparam logic [31:0]      RST_TIMEOUT = 32'd0;

  // A threshold of zero is treated exactly like a threshold of one.
  function automatic logic [CNT_W-1:0] thresh_eff(input logic [CNT_W-1:0] t);
    return (t == '0) ? CNT_W'(1) : t;
  endfunction

endpackage

// File: rtl/spi_irq_prio_enc.sv
// Lowest-index-first priority encoder over the active interrupt vector.
module spi_irq_prio_enc #(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0] req,
  output logic [2:0]      idx,
  output logic            vld
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx = 3'd0;
    vld = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = 3'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_irq_ctrl.sv
// Interrupt aggregator with per-source pending/mask, event-count and timeout
// coalescing, exposed as an Avalon-MM slave register block.
module spi_irq_ctrl
  import spi_irq_pkg::*;
#(
  parameter int NSRC  = 4,
  parameter int TMO_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        avs_s0_write,
  input  logic        avs_s0_read,
  input  logic [15:0] avs_s0_address,
  input  logic [31:0] avs_s0_writedata,
  output logic [31:0] avs_s0_readdata,
  input  logic [NSRC-1:0] irq_src,
  output logic        avm_s0_irq
);

  logic [NSRC-1:0]  pending;
  logic [NSRC-1:0]  mask;
  logic [CNT_W-1:0] thresh;
  logic [TMO_W-1:0] timeout;
  logic [NSRC-1:0]  active;
  logic [NSRC-1:0]  active_p1;
  logic [NSRC-1:0]  ack_clr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic [TMO_W-1:0] timer;
  logic [TMO_W-1:0] timer_inc;
  logic             new_evt;
  logic             coal_hit;
  logic [2:0]       cause_idx;
  logic             cause_vld;
  irq_state_e       state;
  logic             unused_wdata;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [TMO_W-1:0] sat_inc_tmo(input logic [TMO_W-1:0] v);
    return (v == '1) ? v : v + TMO_W'(1);
  endfunction

  assign unused_wdata = ^avs_s0_writedata;

  assign ack_clr = (avs_s0_write && avs_s0_address == ADDR_ACK)
                   ? avs_s0_writedata[NSRC-1:0] : '0;
  assign active  = pending & mask;

  // A source counts as a new event only on its 0->1 edge within ACTIVE,
  // and all edges arriving in the same cycle count once.
  assign new_evt   = |(active & ~active_p1);
  assign count_inc = new_evt ? sat_inc_cnt(count) : count;
  assign timer_inc = sat_inc_tmo(timer);
  assign coal_hit  = (count_inc >= thresh_eff(thresh)) ||
                     ((timeout != '0) && (timer_inc >= timeout));

  spi_irq_prio_enc #(.NSRC(NSRC)) u_prio_enc (
    .req (active),
    .idx (cause_idx),
    .vld (cause_vld)
  );

  // Register file; a new request wins over a same-cycle acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      mask      <= RST_MASK[NSRC-1:0];
      thresh    <= RST_THRESH;
      timeout   <= RST_TIMEOUT[TMO_W-1:0];
      active_p1 <= '0;
    end else begin
      pending   <= (pending & ~ack_clr) | irq_src;
      active_p1 <= active;
      if (avs_s0_write) begin
        case (avs_s0_address)
          ADDR_MASK:    mask    <= avs_s0_writedata[NSRC-1:0];
          ADDR_THRESH:  thresh  <= avs_s0_writedata[CNT_W-1:0];
          ADDR_TIMEOUT: timeout <= avs_s0_writedata[TMO_W-1:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      avs_s0_readdata <= '0;
    end else if (avs_s0_read) begin
      case (avs_s0_address)
        ADDR_MASK:    avs_s0_readdata <= 32'(mask);
        ADDR_PENDING: avs_s0_readdata <= 32'(pending);
        ADDR_CAUSE:   avs_s0_readdata <= {23'd0, cause_vld, 5'd0, cause_idx};
        ADDR_THRESH:  avs_s0_readdata <= 32'(thresh);
        ADDR_TIMEOUT: avs_s0_readdata <= 32'(timeout);
        default:      avs_s0_readdata <= '0;
      endcase
    end
  end

  // Coalescing FSM; the irq output tracks the FIRE state register-for-register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      count      <= '0;
      timer      <= '0;
      avm_s0_irq <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          avm_s0_irq <= 1'b0;
          count      <= '0;
          timer      <= '0;
          if (active != '0) begin
            if (thresh <= CNT_W'(1)) begin
              state      <= ST_FIRE;
              avm_s0_irq <= 1'b1;
            end else begin
              state <= ST_COAL;
              count <= CNT_W'(1);
              timer <= '0;
            end
          end
        end
        ST_COAL: begin
          if (active == '0) begin
            state      <= ST_IDLE;
            avm_s0_irq <= 1'b0;
          end else begin
            count <= count_inc;
            timer <= timer_inc;
            if (coal_hit) begin
              state      <= ST_FIRE;
              avm_s0_irq <= 1'b1;
            end
          end
        end
        ST_FIRE: begin
          avm_s0_irq <= 1'b1;
          if (active == '0) begin
            state      <= ST_IDLE;
            avm_s0_irq <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          avm_s0_irq <= 1'b0;
        end
      endcase
    end
  end

endmodule
